// File: rtl/flipflop_step_ctrl.sv
// ---------------------------------------------------------------------------
// flipflop_step_ctrl
//
// Turns the lab push-button into clean, single-cycle step-enable pulses for
// the D / JK / T flip-flop bank, all inside the fast system clock domain.
// Manual mode: one debounced press produces one pulse on the selected
// flip-flop (or on all three). Auto mode: a free-running timer steps the
// three flip-flops in round-robin order.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synced samples needed to accept a press/release
//   AUTO_PERIOD      cycles between auto-mode steps (>= 2)
//
// Ports:
//   CLK         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   btn_in      raw push-button level (asynchronous to CLK)
//   auto_mode   0 = manual stepping, 1 = round-robin auto stepping
//   sel         manual target: 0 = D, 1 = JK, 2 = T, 3 = all
//   step_en     one-cycle step pulses: bit0 = D, bit1 = JK, bit2 = T
//   busy        manual FSM is not in IDLE
//   rr_ptr      next auto-mode target (0, 1 or 2)
//   step_count  number of cycles with a step pulse (wraps at 256)
//
// Optional feature macro: STEP_COUNT_EN
//   defined   -> step_count is a live 8-bit event counter
//   undefined -> step_count is tied to zero and no counter is built
// ---------------------------------------------------------------------------
module flipflop_step_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] AUTO_PERIOD     = 24'd10000000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       btn_in,
    input  logic       auto_mode,
    input  logic [1:0] sel,
    output logic [2:0] step_en,
    output logic       busy,
    output logic [1:0] rr_ptr,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        FIRE     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [23:0] timer;
    logic        mode_q;
    logic        btn_meta;
    logic        btn_s;

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] rr_onehot(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Two-flop synchronizer for the raw button level
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // Manual debounce FSM, auto timer and the registered step pulse.
    // mode_q remembers last cycle's auto_mode so a mode change is seen as a
    // one-cycle event: the pulse owed by the old mode is still issued, then
    // both engines restart from their idle/zero state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            busy    <= 1'b0;
            step_en <= 3'b000;
            timer   <= 24'd0;
            rr_ptr  <= 2'd0;
            mode_q  <= 1'b0;
        end else begin
            mode_q  <= auto_mode;
            step_en <= 3'b000;
            if (auto_mode != mode_q) begin
                if (mode_q && (timer == AUTO_PERIOD - 24'd1))
                    step_en <= rr_onehot(rr_ptr);
                else if (!mode_q && (state == FIRE))
                    step_en <= sel_onehot(sel);
                timer  <= 24'd0;
                rr_ptr <= 2'd0;
                state  <= IDLE;
                cnt    <= 16'd0;
                busy   <= 1'b0;
            end else if (auto_mode) begin
                state <= IDLE;
                cnt   <= 16'd0;
                busy  <= 1'b0;
                if (timer == AUTO_PERIOD - 24'd1) begin
                    timer   <= 24'd0;
                    step_en <= rr_onehot(rr_ptr);
                    rr_ptr  <= rr_next(rr_ptr);
                end else begin
                    timer <= timer + 24'd1;
                end
            end else begin
                timer  <= 24'd0;
                rr_ptr <= 2'd0;
                case (state)
                    IDLE: begin
                        if (btn_s) begin
                            state <= CONFIRM;
                            cnt   <= 16'd1;
                            busy  <= 1'b1;
                        end
                    end
                    // The press is accepted on the sample after cnt has
                    // reached DEBOUNCE_CYCLES, so the pulse lands
                    // 2 + DEBOUNCE_CYCLES + 1 cycles after the first sample.
                    CONFIRM: begin
                        if (!btn_s) begin
                            state <= IDLE;
                            cnt   <= 16'd0;
                            busy  <= 1'b0;
                        end else if (cnt == DEBOUNCE_CYCLES) begin
                            state <= FIRE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    FIRE: begin
                        step_en <= sel_onehot(sel);
                        state   <= WAIT_REL;
                        cnt     <= 16'd0;
                    end
                    // Release completes on the DEBOUNCE_CYCLES-th consecutive
                    // low sample; any high sample restarts the count.
                    WAIT_REL: begin
                        if (btn_s) begin
                            cnt <= 16'd0;
                        end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                            state <= IDLE;
                            cnt   <= 16'd0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STEP_COUNT_EN
    // One count per pulse cycle; a sel = 3 pulse is a single event
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            step_count <= 8'd0;
        else if (step_en != 3'b000)
            step_count <= step_count + 8'd1;
    end
`else
    assign step_count = 8'd0;
`endif

endmodule

// File: tb/tb_flipflop_step_ctrl.sv
module tb_flipflop_step_ctrl;

    localparam int D = 4;
    localparam int P = 8;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       btn_in;
    logic       auto_mode;
    logic [1:0] sel;
    logic [2:0] step_en;
    logic       busy;
    logic [1:0] rr_ptr;
    logic [7:0] step_count;

    always #5 CLK = ~CLK;

    flipflop_step_ctrl #(
        .DEBOUNCE_CYCLES(16'(D)),
        .AUTO_PERIOD    (24'(P))
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .btn_in    (btn_in),
        .auto_mode (auto_mode),
        .sel       (sel),
        .step_en   (step_en),
        .busy      (busy),
        .rr_ptr    (rr_ptr),
        .step_count(step_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: button as a 2-deep delay line, manual debounce as
    // run lengths of equal samples, auto mode as "every P-th cycle since the
    // mode was entered, target = pulses-so-far mod 3".
    bit         m_s1, m_s2, m_mode, m_armed, m_fire;
    int         m_hi, m_lo, m_n, m_k, m_steps;
    logic [2:0] e_step;
    logic       e_busy;
    logic [1:0] e_rr;
    logic [7:0] e_cnt;

    function automatic logic [2:0] hot3(input int i);
        case (i)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    task automatic manual_clear();
        m_armed = 1'b1;
        m_fire  = 1'b0;
        m_hi    = 0;
        m_lo    = 0;
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_mode = 1'b0;
        manual_clear();
        m_n = 0; m_k = 0; m_steps = 0;
        e_step = 3'b000; e_busy = 1'b0; e_rr = 2'd0; e_cnt = 8'd0;
    endtask

    task automatic model_step();
        logic [2:0] p;
        bit s;
        if (Reset) begin
            model_reset();
            return;
        end
        s = m_s2;
        p = 3'b000;
        if (e_step != 3'b000) m_steps++;
        if (m_mode) begin
            m_n++;
            if (m_n % P == 0) begin
                p = hot3(m_k % 3);
                m_k++;
            end
        end else if (m_fire) begin
            p = hot3(int'(sel));
            m_fire  = 1'b0;
            m_armed = 1'b0;
            m_lo    = 0;
        end else if (m_armed) begin
            if (s) m_hi++; else m_hi = 0;
            if (m_hi == D + 1) begin
                m_fire = 1'b1;
                m_hi   = 0;
            end
        end else begin
            if (s) m_lo = 0; else m_lo++;
            if (m_lo == D) begin
                m_armed = 1'b1;
                m_lo    = 0;
            end
        end
        if (auto_mode != m_mode) begin
            m_mode = auto_mode;
            m_n = 0;
            m_k = 0;
            manual_clear();
        end
        e_step = p;
        e_busy = !m_armed || m_fire || (m_hi > 0);
        e_rr   = m_mode ? 2'(m_k % 3) : 2'd0;
`ifdef STEP_COUNT_EN
        e_cnt  = 8'(m_steps);
`else
        e_cnt  = 8'd0;
`endif
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_val("step_en",    32'(step_en),    32'(e_step));
        check_val("busy",       32'(busy),       32'(e_busy));
        check_val("rr_ptr",     32'(rr_ptr),     32'(e_rr));
        check_val("step_count", 32'(step_count), 32'(e_cnt));
    endtask

    initial begin
        int first, npulse, busy_low, guard, run;
        logic [2:0] val;
        int apos[$];
        logic [2:0] aval[$];
        logic [7:0] prev_cnt;
        bit saw_wrap;

        Reset = 1'b1; btn_in = 1'b0; auto_mode = 1'b0; sel = 2'd0;
        model_reset();
        repeat (3) tick();
        Reset = 1'b0;
        repeat (5) tick();

        // Clean press, sel = 1, held 20 cycles
        sel = 2'd1; btn_in = 1'b1;
        first = -1; npulse = 0; val = 3'b000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_en != 3'b000) begin
                npulse++;
                if (first < 0) begin first = i; val = step_en; end
            end
        end
        btn_in = 1'b0;
        busy_low = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy && busy_low < 0) busy_low = i;
        end
        check_val("press_latency", 32'(first), 32'd7);
        check_val("press_value",   32'(val),   32'b010);
        check_val("press_npulse",  32'(npulse), 32'd1);
        check_val("release_busy",  32'(busy_low), 32'd5);

        // Bounce: high 2 / low 1, five times
        npulse = 0;
        for (int r = 0; r < 5; r++) begin
            btn_in = 1'b1;
            repeat (2) begin tick(); if (step_en != 3'b000) npulse++; end
            btn_in = 1'b0;
            tick(); if (step_en != 3'b000) npulse++;
        end
        repeat (12) begin tick(); if (step_en != 3'b000) npulse++; end
        check_val("bounce_npulse", 32'(npulse), 32'd0);

        // Reset asserted in the middle of CONFIRM
        btn_in = 1'b1;
        repeat (4) tick();
        check_val("confirm_busy", 32'(busy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check_val("rst_step_en",    32'(step_en),    32'd0);
        check_val("rst_busy",       32'(busy),       32'd0);
        check_val("rst_rr_ptr",     32'(rr_ptr),     32'd0);
        check_val("rst_step_count", 32'(step_count), 32'd0);
        model_reset();
        repeat (2) tick();
        Reset = 1'b0; btn_in = 1'b0;
        npulse = 0;
        repeat (12) begin tick(); if (step_en != 3'b000) npulse++; end
        check_val("post_rst_npulse", 32'(npulse), 32'd0);

        // sel = 3, button held 100 cycles
        sel = 2'd3; btn_in = 1'b1; npulse = 0; val = 3'b000;
        repeat (100) begin
            tick();
            if (step_en != 3'b000) begin npulse++; val = step_en; end
        end
        btn_in = 1'b0;
        repeat (12) tick();
        check_val("all_npulse", 32'(npulse), 32'd1);
        check_val("all_value",  32'(val),    32'b111);

        // Auto round-robin, button and sel ignored
        auto_mode = 1'b1;
        for (int i = 0; i < 49; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            sel    = 2'($urandom_range(0, 3));
            tick();
            if (step_en != 3'b000) begin apos.push_back(i); aval.push_back(step_en); end
        end
        check_val("auto_npulse", 32'(apos.size()), 32'd6);
        for (int j = 0; j < apos.size() && j < 6; j++) begin
            check_val("auto_pos", 32'(apos[j]), 32'(P * (j + 1)));
            check_val("auto_val", 32'(aval[j]), 32'(hot3(j % 3)));
        end

        // Mode switch with rr_ptr = 2
        btn_in = 1'b0;
        guard = 0;
        while (rr_ptr != 2'd2 && guard < 40) begin tick(); guard++; end
        check_val("rr_before_switch", 32'(rr_ptr), 32'd2);
        auto_mode = 1'b0;
        tick();
        check_val("rr_after_switch", 32'(rr_ptr), 32'd0);
        repeat (4) tick();
        sel = 2'd2; btn_in = 1'b1; val = 3'b000;
        repeat (20) begin tick(); if (step_en != 3'b000) val = step_en; end
        btn_in = 1'b0;
        repeat (12) tick();
        check_val("switch_press_value", 32'(val), 32'b100);

        // Long auto run so the step counter wraps
        auto_mode = 1'b1;
        saw_wrap = 1'b0;
        prev_cnt = step_count;
        repeat (260 * P + 4) begin
            tick();
            if (prev_cnt == 8'd255 && step_count == 8'd0) saw_wrap = 1'b1;
            prev_cnt = step_count;
        end
`ifdef STEP_COUNT_EN
        check_val("count_wrap", 32'(saw_wrap), 32'd1);
`else
        check_val("count_tied", 32'(saw_wrap), 32'd0);
`endif
        auto_mode = 1'b0;
        repeat (4) tick();

        // Randomized traffic: long/short button runs, mode flips, resets
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (Reset) Reset = 1'b0;
            if (run == 0) begin
                btn_in = ~btn_in;
                run = $urandom_range(1, 12);
            end
            run--;
            if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 699) == 0) Reset = 1'b1;
            tick();
        end
        Reset = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flipflop_step_ctrl.md
Name: flipflop_step_ctrl

Overview:
Clock-step controller for the flip-flop lab datapath (D, JK and T flip-flop instances). It replaces the raw push-button clock with debounced, single-cycle step-enable pulses generated in the fast system clock domain. It has two modes. In manual mode, one button press steps a selected flip-flop or all three. In auto mode, a programmable timer steps the three flip-flops in round-robin order. Sits between the board button/switches and the clock-enable inputs of the flip-flop bank.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable synced samples required to accept a press or a release; legal range 1..65535
AUTO_PERIOD, 24'd10000000, cycles between auto-mode steps; legal range 2..2^24-1

Ports:
CLK  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-high reset
btn_in  input  1  raw push-button level, asynchronous to CLK
auto_mode  input  1  0 = manual stepping, 1 = round-robin auto stepping
sel  input  2  manual target: 0 = D, 1 = JK, 2 = T, 3 = all
step_en  output  3  one-cycle step pulses: bit0 = D, bit1 = JK, bit2 = T
busy  output  1  manual FSM not in IDLE
rr_ptr  output  2  next auto-mode target: 0, 1 or 2
step_count  output  8  number of step events issued (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-debounce or mid-pulse): FSM = IDLE; step_en = 0; busy = 0; rr_ptr = 0; auto timer = 0; debounce counter = 0; sync flops = 0; step_count = 0.
- btn_in passes through a 2-flop synchronizer; the output is btn_s. Only btn_s is used internally.
- Manual FSM (active when auto_mode = 0):
  - IDLE: if btn_s = 1, go to CONFIRM and set cnt = 1.
  - CONFIRM: if btn_s = 0, go to IDLE and clear cnt. Otherwise increment cnt. When cnt = DEBOUNCE_CYCLES, go to FIRE.
  - FIRE: exactly one cycle. step_en = one-hot of the sel value sampled in this cycle; sel = 3 gives 3'b111. Then go to WAIT_REL and clear cnt.
  - WAIT_REL: if btn_s = 1, clear cnt. Otherwise increment cnt. When cnt = DEBOUNCE_CYCLES, go to IDLE.
  - Result: exactly one pulse per accepted press, and holding the button never repeats.
- Manual latency: a btn_in rising edge held stable produces step_en high in cycle 2 + DEBOUNCE_CYCLES + 1 after it is first sampled.
- Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Auto mode (auto_mode = 1):
  - Manual FSM is forced to IDLE, and the button is ignored.
  - The timer counts 0..AUTO_PERIOD-1. At the wrap cycle, step_en = one-hot(rr_ptr) for one cycle, then rr_ptr advances 0→1→2→0.
  - sel is ignored.
- auto_mode transitions (either direction) take effect on the next edge:
  - Timer and rr_ptr clear to 0, and the manual FSM goes to IDLE.
  - A pulse in the same cycle as the transition is still issued; no pulse is lost or duplicated.
- step_en is registered, so it is glitch-free, and is never high for two consecutive cycles.
- busy = (state != IDLE); busy is always 0 in auto mode.

Optional Feature:
STEP_COUNT_EN
- Defined: step_count is an 8-bit register that increments by 1 on every cycle step_en != 0. A sel = 3 pulse counts as one step. The count wraps 255→0 and is cleared by Reset.
- Undefined: no counter logic is synthesized, and step_count is tied to 8'd0.

Test Plan:
- Reset test: assert Reset mid-CONFIRM, DEBOUNCE_CYCLES = 4 → all outputs 0 immediately; after release, FSM is IDLE and no stray pulse appears.
- Clean press, manual mode, DEBOUNCE_CYCLES = 4, sel = 1, btn_in held 20 cycles → step_en = 3'b010 for exactly one cycle, 7 cycles after the press; busy returns to 0 four cycles after btn_s falls.
- Bounce rejection: btn_in toggles high 2 cycles / low 1 cycle, five times, then stays low → step_en stays 0 throughout.
- Select all plus hold: sel = 3, button held 100 cycles → a single pulse of 3'b111, no repeat; step_count = 1 with STEP_COUNT_EN.
- Auto round-robin: auto_mode = 1, AUTO_PERIOD = 8, run 48 cycles → pulses at cycles 8, 16, 24, ... with values 001, 010, 100, 001, 010, 100; the button is ignored throughout.
- Mode switch: switch auto_mode 1→0 with rr_ptr = 2 → rr_ptr = 0 next cycle; a subsequent press obeys sel; step_count wraps from 255 to 0 after 256 steps.
